// File: rtl/x1_ioctl_loader.sv
// Purpose: receives the HPS ioctl download stream and routes each byte by ioctl_index to the IPL ROM, CG ROM or main RAM write port, or discards it.
// Latency: a push at edge N raises mem_req at edge N+1 at the earliest; each write takes at least 2 cycles (req, ack/pop).
// Backpressure: ioctl_wait is registered and goes high while FIFO occupancy is >= depth-1; bytes strobed into a full FIFO are dropped and flagged in err_ovf.
//
// Ports:
//   clk_sys, reset            : single clock, synchronous active-high reset
//   ioctl_download/index/wr   : download window, target selector, one-cycle byte strobe
//   ioctl_addr/dout           : byte address (bits above AW-1 must be zero) and byte data
//   ioctl_wait                : back-pressure toward the HPS
//   mem_req/sel/addr/data     : write request toward the ROM/RAM side (sel 0 IPL, 1 CG, 2 main RAM)
//   mem_ack                   : target accepted the current write
//   busy/done                 : busy in ACTIVE or DRAIN; one-cycle done pulse at completion
//   err_ovf/err_range         : sticky error flags, cleared at download start
//   cksum                     : running byte checksum
//
// Optional feature: define LOADER_CKSUM_EN to build the checksum adder; otherwise cksum is tied to zero.

module x1_ioctl_loader #(
  parameter int AW        = 16,
  parameter int FIFO_LOG2 = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [1:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic          err_ovf,
  output logic          err_range,
  output logic [15:0]   cksum
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] CNT_FULL = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0] CNT_HIGH = (FIFO_LOG2+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } entry_t;

  state_t state, state_nxt;

  entry_t               fifo_mem [DEPTH];
  entry_t               head;
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]   count, count_nxt;

  logic       dl_q;
  logic       dl_rise, dl_fall;
  logic       start;
  logic [7:0] idx_q;
  logic       tgt_ok;
  logic [1:0] tgt_sel;
  logic       strobe;
  logic       in_range;
  logic       fifo_full;
  logic       push, pop;
  logic       drop_ovf, drop_rng;

  // Edge detection uses the registered previous value of ioctl_download.
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign start   = (state == S_IDLE) && dl_rise;

  // Target decode from the index latched at download start.
  always_comb begin
    tgt_ok  = 1'b1;
    tgt_sel = 2'd0;
    case (idx_q)
      8'd0:    tgt_sel = 2'd0;
      8'd1:    tgt_sel = 2'd1;
      8'd2:    tgt_sel = 2'd2;
      default: tgt_ok  = 1'b0;
    endcase
  end

  assign strobe    = (state == S_ACTIVE) && ioctl_wr && ioctl_download;
  assign in_range  = (ioctl_addr >> AW) == 25'd0;
  assign fifo_full = (count == CNT_FULL);
  assign pop       = mem_req && mem_ack;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = strobe && in_range && tgt_ok && (!fifo_full || pop);
  assign drop_ovf  = strobe && in_range && tgt_ok && fifo_full && !pop;
  assign drop_rng  = strobe && !in_range;

  assign count_nxt = count + (FIFO_LOG2+1)'(push) - (FIFO_LOG2+1)'(pop);
  assign head      = fifo_mem[rd_ptr];

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (dl_rise) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        busy = 1'b1;
        if (dl_fall) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((count == '0) && !mem_req) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk_sys) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= '{sel: tgt_sel, addr: ioctl_addr[AW-1:0], data: ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q       <= 1'b0;
      idx_q      <= 8'd0;
      err_ovf    <= 1'b0;
      err_range  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_sel    <= 2'd0;
      mem_addr   <= '0;
      mem_data   <= 8'd0;
    end else begin
      dl_q <= ioctl_download;

      if (start) begin
        idx_q     <= ioctl_index;
        err_ovf   <= 1'b0;
        err_range <= 1'b0;
      end else begin
        if (drop_ovf) err_ovf   <= 1'b1;
        if (drop_rng) err_range <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      count      <= count_nxt;
      ioctl_wait <= (count_nxt >= CNT_HIGH);

      // The head entry stays in the FIFO until acked; the ack cycle pops it
      // and drops mem_req, so the next request can follow one cycle later.
      if (pop) begin
        mem_req <= 1'b0;
      end else if (!mem_req && (count != '0)) begin
        mem_req  <= 1'b1;
        mem_sel  <= head.sel;
        mem_addr <= head.addr;
        mem_data <= head.data;
      end
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [15:0] cksum_q;
  logic        ck_add;

  // Discard-target bytes count; overflow-dropped and out-of-range bytes do not.
  assign ck_add = strobe && in_range && !drop_ovf;

  always_ff @(posedge clk_sys) begin
    if (reset)       cksum_q <= 16'h0000;
    else if (start)  cksum_q <= 16'h0000;
    else if (ck_add) cksum_q <= cksum_q + {8'h00, ioctl_dout};
  end

  assign cksum = cksum_q;
`else
  assign cksum = 16'h0000;
`endif

endmodule

// File: tb/tb_x1_ioctl_loader.sv
// Directed bench for x1_ioctl_loader: a cycle table covering the basic
// download, FIFO overflow and mid-transfer reset, followed by hand-written
// sequences for the out-of-range address, discard target and full-FIFO
// push+pop corner cases.
module tb_x1_ioctl_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err_ovf;
  logic        err_range;
  logic [15:0] cksum;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LOADER_CKSUM_EN
  localparam logic [15:0] CK_MASK = 16'hFFFF;
`else
  localparam logic [15:0] CK_MASK = 16'h0000;
`endif

  x1_ioctl_loader #(.AW(16), .FIFO_LOG2(2)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_sel        (mem_sel),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .done           (done),
    .err_ovf        (err_ovf),
    .err_range      (err_range),
    .cksum          (cksum)
  );

  always #5 clk_sys = ~clk_sys;

  // One table row: inputs applied before an edge, outputs expected after it.
  // e_flags = {ioctl_wait, busy, done, err_ovf, err_range}
  typedef struct packed {
    logic        rst;
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        ack;
    logic        e_req;
    logic [1:0]  e_sel;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    logic [4:0]  e_flags;
    logic        ck_on;
    logic [15:0] e_ck;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic dl, input logic [7:0] idx,
                              input logic wr, input logic [24:0] a, input logic [7:0] d,
                              input logic ack, input logic req, input logic [1:0] sel,
                              input logic [15:0] ea, input logic [7:0] ed,
                              input logic [4:0] fl, input int ck);
    vec_t v;
    v.rst = rst;  v.dl = dl;  v.idx = idx;  v.wr = wr;  v.addr = a;  v.dout = d;
    v.ack = ack;  v.e_req = req;  v.e_sel = sel;  v.e_addr = ea;  v.e_data = ed;
    v.e_flags = fl;
    v.ck_on = (ck >= 0);
    v.e_ck  = 16'(ck);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dl, input logic [7:0] idx, input logic wr,
                       input logic [24:0] a, input logic [7:0] d, input logic ack);
    ioctl_download = dl;
    ioctl_index    = idx;
    ioctl_wr       = wr;
    ioctl_addr     = a;
    ioctl_dout     = d;
    mem_ack        = ack;
  endtask

  // Waits (bounded) for a request, checks it, then lets the held-high ack pop it.
  task automatic collect_write(input string name, input logic [1:0] sel,
                               input logic [15:0] a, input logic [7:0] d);
    int k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    check({name, " req"}, {31'd0, mem_req}, 32'd1);
    if (mem_req) begin
      check({name, " sel/addr/data"}, {6'd0, mem_sel, mem_addr, mem_data}, {6'd0, sel, a, d});
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(0, 8'd0, 0, 25'd0, 8'h00, 0);

    // Test 1: index 0, 4 bytes, ack held high.
    tbl.push_back(mk(0,1,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd0,1,25'd0,8'h11,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd0,1,25'd1,8'h22,1, 1,2'd0,16'h0,8'h11,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd0,1,25'd2,8'h33,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd0,1,25'd3,8'h44,1, 1,2'd0,16'h1,8'h22,5'b11000,-1));
    tbl.push_back(mk(0,1,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 1,2'd0,16'h2,8'h33,5'b01000,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 1,2'd0,16'h3,8'h44,5'b01000,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b00100,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b00000,'h00AA));
    // Test 2: index 2, ack low, FIFO fills, 5th byte overflows, then drain.
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,0, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd2,1,25'd0,8'h01,0, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd2,1,25'd1,8'h02,0, 1,2'd2,16'h0,8'h01,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd2,1,25'd2,8'h03,0, 1,2'd2,16'h0,8'h01,5'b11000,-1));
    tbl.push_back(mk(0,1,8'd2,1,25'd3,8'h04,0, 1,2'd2,16'h0,8'h01,5'b11000,-1));
    tbl.push_back(mk(0,1,8'd2,1,25'd4,8'h05,0, 1,2'd2,16'h0,8'h01,5'b11010,-1));
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b11010,-1));
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,1, 1,2'd2,16'h1,8'h02,5'b11010,-1));
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01010,-1));
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,1, 1,2'd2,16'h2,8'h03,5'b01010,-1));
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01010,-1));
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,1, 1,2'd2,16'h3,8'h04,5'b01010,-1));
    tbl.push_back(mk(0,1,8'd2,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01010,-1));
    tbl.push_back(mk(0,0,8'd2,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01010,-1));
    tbl.push_back(mk(0,0,8'd2,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b00110,-1));
    tbl.push_back(mk(0,0,8'd2,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b00010,'h000A));
    // Test 5: reset with a request outstanding and 2 entries queued, then a clean download.
    tbl.push_back(mk(0,1,8'd1,0,25'd0,8'h00,0, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd1,1,25'd5,8'hAA,0, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd1,1,25'd6,8'hBB,0, 1,2'd1,16'h5,8'hAA,5'b01000,-1));
    tbl.push_back(mk(1,0,8'd1,0,25'd0,8'h00,0, 0,2'd0,16'h0,8'h00,5'b00000,'h0000));
    tbl.push_back(mk(0,0,8'd1,0,25'd0,8'h00,0, 0,2'd0,16'h0,8'h00,5'b00000,-1));
    tbl.push_back(mk(0,1,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd0,1,25'd7,8'h55,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd0,0,25'd0,8'h00,1, 1,2'd0,16'h7,8'h55,5'b01000,-1));
    tbl.push_back(mk(0,1,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b01000,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b00100,-1));
    tbl.push_back(mk(0,0,8'd0,0,25'd0,8'h00,1, 0,2'd0,16'h0,8'h00,5'b00000,'h0055));

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset mem outputs", {5'd0, mem_req, mem_sel, mem_addr, mem_data}, 32'd0);
    check("reset flags", {27'd0, ioctl_wait, busy, done, err_ovf, err_range}, 32'd0);
    check("reset cksum", {16'd0, cksum}, 32'd0);

    // Table-driven part
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      reset = t.rst;
      drive(t.dl, t.idx, t.wr, t.addr, t.dout, t.ack);
      tick();
      check($sformatf("row%0d req", i), {31'd0, mem_req}, {31'd0, t.e_req});
      check($sformatf("row%0d flags", i),
            {27'd0, ioctl_wait, busy, done, err_ovf, err_range}, {27'd0, t.e_flags});
      if (t.e_req)
        check($sformatf("row%0d sel/addr/data", i),
              {6'd0, mem_sel, mem_addr, mem_data}, {6'd0, t.e_sel, t.e_addr, t.e_data});
      if (t.ck_on)
        check($sformatf("row%0d cksum", i), {16'd0, cksum}, {16'd0, t.e_ck & CK_MASK});
    end
    reset = 1'b0;

    // Out-of-range address, then a normal byte.
    drive(1, 8'd0, 0, 25'd0, 8'h00, 1);
    tick();
    check("range start busy", {31'd0, busy}, 32'd1);
    drive(1, 8'd0, 1, 25'h10000, 8'h77, 1);
    tick();
    check("range err set", {31'd0, err_range}, 32'd1);
    check("range no req", {31'd0, mem_req}, 32'd0);
    drive(1, 8'd0, 1, 25'h00010, 8'h66, 1);
    tick();
    check("range dropped byte not queued", {31'd0, mem_req}, 32'd0);
    drive(1, 8'd0, 0, 25'd0, 8'h00, 1);
    tick();
    check("range good byte written",
          {5'd0, mem_req, mem_sel, mem_addr, mem_data}, {5'd0, 1'b1, 2'd0, 16'h0010, 8'h66});
    tick();
    check("range req cleared", {31'd0, mem_req}, 32'd0);
    drive(0, 8'd0, 0, 25'd0, 8'h00, 1);
    tick();
    tick();
    check("range done", {31'd0, done}, 32'd1);
    check("range errs sticky", {30'd0, err_ovf, err_range}, {30'd0, 2'b01});
    check("range cksum", {16'd0, cksum}, {16'd0, 16'h0066 & CK_MASK});
    tick();

    // Discard target: bytes never reach the memory side.
    drive(1, 8'd7, 0, 25'd0, 8'h00, 1);
    tick();
    check("discard err cleared", {31'd0, err_range}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'd7, 1, 25'(i), 8'((i + 1) * 16), 1);
      tick();
      check($sformatf("discard byte%0d no req", i), {31'd0, mem_req}, 32'd0);
    end
    drive(1, 8'd7, 0, 25'd0, 8'h00, 1);
    tick();
    check("discard idle req/wait", {30'd0, mem_req, ioctl_wait}, 32'd0);
    drive(0, 8'd7, 0, 25'd0, 8'h00, 1);
    tick();
    check("discard drain", {30'd0, busy, done}, {30'd0, 2'b10});
    tick();
    check("discard done", {30'd0, busy, done}, {30'd0, 2'b01});
    check("discard cksum", {16'd0, cksum}, {16'd0, 16'h0060 & CK_MASK});
    tick();

    // Full FIFO with a simultaneous ack and strobe: push and pop both happen.
    drive(1, 8'd2, 0, 25'd0, 8'h00, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'd2, 1, 25'(i), 8'(8'hA1 + i), 0);
      tick();
    end
    check("full wait", {31'd0, ioctl_wait}, 32'd1);
    check("full head req", {7'd0, mem_req, mem_data}, {7'd0, 1'b1, 8'hA1});
    drive(1, 8'd2, 1, 25'd4, 8'hA5, 1);
    tick();
    check("full push+pop no ovf", {31'd0, err_ovf}, 32'd0);
    check("full push+pop count kept", {30'd0, ioctl_wait, mem_req}, {30'd0, 2'b10});
    drive(1, 8'd2, 0, 25'd0, 8'h00, 1);
    collect_write("full w1", 2'd2, 16'h1, 8'hA2);
    collect_write("full w2", 2'd2, 16'h2, 8'hA3);
    collect_write("full w3", 2'd2, 16'h3, 8'hA4);
    collect_write("full w4", 2'd2, 16'h4, 8'hA5);
    drive(0, 8'd2, 0, 25'd0, 8'h00, 1);
    tick();
    tick();
    check("full done", {31'd0, done}, 32'd1);
    check("full errs", {30'd0, err_ovf, err_range}, 32'd0);
    check("full cksum", {16'd0, cksum}, {16'd0, 16'h032F & CK_MASK});
    tick();
    check("full after done", {30'd0, busy, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
